tdc_measure_ctrl: RTL
=====================

// Module: tdc_measure_ctrl
// PURPOSE
//   Sequences repeated measurements on the 32-tap TDC delay line. Per sample: clears the line,
//   launches a start edge, waits a settle window, captures the thermometer code, popcounts it.
//   Accumulates N_SAMPLES counts into one result, returned over a valid/ready handshake.
//   Sits between the tile's ui_in/uo_out pins and the delay line.
// PARAMETERS
//   N_DELAY       32  delay-line taps (width of tdc_code)
//   N_SAMPLES     8   samples per result; power of two, >=1
//   SETTLE_CYCLES 2   cycles tdc_start stays high before capture; >=1
//   CNT_W, RES_W  localparams: CNT_W=$clog2(N_DELAY+1)=6, RES_W=CNT_W+$clog2(N_SAMPLES)=9
// PORTS
//   clk          in   1        system clock
//   rst_n        in   1        reset, asynchronous, active-high
//   req_start    in   1        measurement request, level-sampled in IDLE
//   busy         out  1        high in every state except IDLE
//   tdc_start    out  1        start edge to delay line
//   tdc_code     in   N_DELAY  thermometer code from delay line
//   result       out  RES_W    accumulated popcount, stable while result_valid
//   result_valid out  1        result available
//   result_ready in   1        consumer accepts result
//   byte_sel     in   2        selects 8-bit slice of zero-extended 32-bit result
//   result_byte  out  8        combinational slice: 0=[7:0] 1=[15:8] 2=[23:16] 3=[31:24]
// BEHAVIOUR
//   Reset (rst_n=1, async): state=IDLE; tdc_start=0, busy=0, result=0, result_valid=0,
//     accumulator=0, sample_idx=0, capture reg=0. Reset mid-measurement aborts with no result.
//   FSM (one state per cycle unless noted):
//     IDLE    : tdc_start=0; req_start=1 -> ARM, acc<=0, sample_idx<=0
//     ARM     : tdc_start=0 (line drains) -> LAUNCH
//     LAUNCH  : tdc_start=1 -> SETTLE
//     SETTLE  : tdc_start=1 for SETTLE_CYCLES cycles -> CAPTURE
//     CAPTURE : tdc_start=1; code_reg<=tdc_code -> ACCUM
//     ACCUM   : tdc_start=0; acc<=acc+popcount(code_reg); last sample -> DONE, else
//               sample_idx++ -> ARM
//     DONE    : result_valid=1, result=acc; result_ready=1 -> IDLE
//   Latency: result_valid rises exactly N_SAMPLES*(4+SETTLE_CYCLES) cycles after the
//     accepting edge (48 at defaults).
//   Handshake: result, result_valid held until result_ready=1 in DONE. result_valid drops
//     next cycle.
//   Simultaneous req_start=1 and result_ready=1 in DONE: result consumed, FSM enters IDLE.
//     The request is taken in IDLE the following cycle if still high.
//   req_start while busy: ignored, no queueing.
//   Arithmetic: popcount is unsigned CNT_W. acc is RES_W, cannot overflow
//     (max N_DELAY*N_SAMPLES=256 < 2^9).
//   Codes: all-ones counts N_DELAY; all-zeros counts 0; non-thermometer codes counted per
//     CONFIGURATION.
//   result_byte: upper bytes of zero-extended result read 0.
// CONFIGURATION
//   TDC_BUBBLE_FIX_EN defined: before popcount, each code_reg bit i is replaced by
//     majority(bit i-1, i, i+1). Out-of-range neighbours: bit -1 reads 1, bit N_DELAY reads 0.
//     Isolated bubbles are removed. Adds no cycles.
//   Not defined: raw popcount of code_reg. Logic is otherwise identical.
// STRUCTURE
//   Package tdc_pkg: state enum (IDLE, ARM, LAUNCH, SETTLE, CAPTURE, ACCUM, DONE),
//     N_DELAY default, CNT_W/RES_W helper functions.
//   Sub-module tdc_therm_count: combinational bubble filter (under macro) plus popcount,
//     N_DELAY-bit in, CNT_W-bit out.
//   FSM, settle counter, sample counter, accumulator and byte mux stay in this module.
// TESTING
//   1. tdc_code=32'h0000FFFF constant, req_start pulse, defaults -> result_valid at +48
//      cycles, result=128, result_byte(sel 0)=8'h80, (sel 1)=8'h00.
//   2. tdc_code=32'hFFFFFFFF -> result=256; byte_sel=1 -> 8'h01; tdc_code=0 -> result=0.
//   3. tdc_code=32'h000000F7: without TDC_BUBBLE_FIX_EN -> 7/sample, result=56;
//      with it -> 8/sample, result=64.
//   4. Hold result_ready=0 for 20 cycles in DONE -> result_valid and result stay stable;
//      req_start pulses are ignored; ready=1 -> IDLE, busy=0.
//   5. Assert rst_n during SETTLE of sample 3 -> tdc_start=0, busy=0, result_valid=0
//      immediately; next request returns the full 8-sample result.
//   6. tdc_start trace per sample: low 1 cycle, high 2+SETTLE_CYCLES cycles, low 1 cycle.
//      Check with SETTLE_CYCLES=1 and 5.

Source files
------------

// File: rtl/tdc_pkg.sv
// tdc_pkg: shared state encoding, default line length and width helpers for the TDC slice.
package tdc_pkg;

    typedef enum logic [2:0] {IDLE, ARM, LAUNCH, SETTLE, CAPTURE, ACCUM, DONE} state_t;

    localparam int TDC_N_DELAY = 32;

    function automatic int cnt_w(input int n_delay);
        return $clog2(n_delay + 1);
    endfunction

    function automatic int res_w(input int n_delay, input int n_samples);
        return cnt_w(n_delay) + $clog2(n_samples);
    endfunction

endpackage

// File: rtl/tdc_therm_count.sv
// tdc_therm_count: popcount of a thermometer code; TDC_BUBBLE_FIX_EN adds a 3-tap majority filter.
module tdc_therm_count
    import tdc_pkg::*;
#(
    parameter int N_DELAY = TDC_N_DELAY,
    localparam int CNT_W = cnt_w(N_DELAY)
) (
    input  logic [N_DELAY-1:0] code,
    output logic [CNT_W-1:0]   count
);

    logic [N_DELAY-1:0] filt;

`ifdef TDC_BUBBLE_FIX_EN
    // Pad with the values a clean thermometer code implies past its ends.
    logic [N_DELAY+1:0] ext;
    assign ext = {1'b0, code, 1'b1};
    always_comb begin
        filt = '0;
        for (int i = 0; i < N_DELAY; i++)
            filt[i] = (ext[i] & ext[i+1]) | (ext[i] & ext[i+2]) | (ext[i+1] & ext[i+2]);
    end
`else
    assign filt = code;
`endif

    always_comb begin
        count = '0;
        for (int i = 0; i < N_DELAY; i++)
            count = count + CNT_W'(filt[i]);
    end

endmodule

// File: rtl/tdc_measure_ctrl.sv
// tdc_measure_ctrl: runs N_SAMPLES clear/launch/settle/capture cycles on the TDC line and
// returns the summed popcount over valid/ready; TDC_BUBBLE_FIX_EN enables the bubble filter.
module tdc_measure_ctrl
    import tdc_pkg::*;
#(
    parameter int N_DELAY       = TDC_N_DELAY,
    parameter int N_SAMPLES     = 8,
    parameter int SETTLE_CYCLES = 2,
    localparam int CNT_W = cnt_w(N_DELAY),
    localparam int RES_W = res_w(N_DELAY, N_SAMPLES)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_start,
    output logic               busy,
    output logic               tdc_start,
    input  logic [N_DELAY-1:0] tdc_code,
    output logic [RES_W-1:0]   result,
    output logic               result_valid,
    input  logic               result_ready,
    input  logic [1:0]         byte_sel,
    output logic [7:0]         result_byte
);

    localparam int SIW = N_SAMPLES > 1 ? $clog2(N_SAMPLES) : 1;
    localparam int STW = $clog2(SETTLE_CYCLES + 1);

    state_t             state, state_nx;
    logic [STW-1:0]     settle_cnt;
    logic [SIW-1:0]     sample_idx;
    logic [RES_W-1:0]   acc;
    logic [N_DELAY-1:0] code_reg;
    logic [CNT_W-1:0]   count;
    logic               last_settle, last_sample;
    logic [31:0]        res_ext;

    tdc_therm_count #(.N_DELAY(N_DELAY)) u_count (.code(code_reg), .count(count));

    assign last_settle = settle_cnt == STW'(SETTLE_CYCLES - 1);
    assign last_sample = sample_idx == SIW'(N_SAMPLES - 1);

    always_comb begin
        state_nx     = state;
        busy         = state != IDLE;
        tdc_start    = state inside {LAUNCH, SETTLE, CAPTURE};
        result_valid = state == DONE;
        case (state)
            IDLE:    state_nx = req_start ? ARM : IDLE;
            ARM:     state_nx = LAUNCH;
            LAUNCH:  state_nx = SETTLE;
            SETTLE:  state_nx = last_settle ? CAPTURE : SETTLE;
            CAPTURE: state_nx = ACCUM;
            ACCUM:   state_nx = last_sample ? DONE : ARM;
            DONE:    state_nx = result_ready ? IDLE : DONE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state      <= IDLE;
            settle_cnt <= '0;
            sample_idx <= '0;
            acc        <= '0;
            code_reg   <= '0;
        end else begin
            state      <= state_nx;
            settle_cnt <= state == SETTLE ? settle_cnt + STW'(1) : '0;
            if (state == IDLE && req_start) begin
                acc        <= '0;
                sample_idx <= '0;
            end
            if (state == CAPTURE)
                code_reg <= tdc_code;
            if (state == ACCUM) begin
                acc <= acc + RES_W'(count);
                if (!last_sample)
                    sample_idx <= sample_idx + SIW'(1);
            end
        end
    end

    assign result      = acc;
    assign res_ext     = 32'(acc);
    assign result_byte = res_ext[{byte_sel, 3'b000} +: 8];

endmodule
